// File: rtl/rx_data_path_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_data_path_if
// Brief    : Host-side handshake and status bundle for the receive datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface rx_data_path_if #(
    parameter int WIDTH = 32
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             StartRX;
    logic             ShiftRX;
    logic             RXIn;
    logic             RXFlush;
    logic             RXRead;
    logic             ClearOvf;
    logic [WIDTH-1:0] RXOut;
    logic             RXValid;
    logic             RXBuff0Full;
    logic             RXBuff1Full;
    logic             wrSel;
    logic             rdSel;
    logic [CNT_W-1:0] bitCount;
    logic             overflow;

    modport master (
        output StartRX, ShiftRX, RXIn, RXFlush, RXRead, ClearOvf,
        input  RXOut, RXValid, RXBuff0Full, RXBuff1Full, wrSel, rdSel,
               bitCount, overflow
    );

    modport slave (
        input  StartRX, ShiftRX, RXIn, RXFlush, RXRead, ClearOvf,
        output RXOut, RXValid, RXBuff0Full, RXBuff1Full, wrSel, rdSel,
               bitCount, overflow
    );
endinterface
`default_nettype wire

// File: rtl/rx_data_path.sv
`default_nettype none
// ============================================================================
// Module   : rx_data_path
// Brief    : Serial-to-parallel receiver with ping-pong word buffers,
//            valid/read handshake and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module rx_data_path #(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    rx_data_path_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_buf [2];
    logic [1:0]       r_full;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_overflow;

    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_shifted;
    logic             w_shift_req;
    logic             w_accept;
    logic             w_complete;
    logic             w_drop;
    logic             w_read;
    logic [1:0]       w_full_nxt;

    assign w_cur       = r_buf[r_wr_sel];
    assign w_shift_req = bus.StartRX & bus.ShiftRX;
    // A flush wins over a same-cycle strobe, so the strobe is simply not accepted.
    assign w_accept    = w_shift_req & ~r_full[r_wr_sel] & ~bus.RXFlush;
    assign w_complete  = w_accept & (r_bit_cnt == c_last_bit);
    assign w_drop      = w_shift_req & r_full[r_wr_sel];
    assign w_read      = bus.RXRead & r_full[r_rd_sel];

    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_shifted = {w_cur[WIDTH-2:0], bus.RXIn};
    end else begin : g_lsb_first
        assign w_shifted = {bus.RXIn, w_cur[WIDTH-1:1]};
    end

    // Read and completion always target different buffers, so set and clear never collide.
    assign w_full_nxt[0] = (r_full[0] & ~(w_read & ~r_rd_sel)) | (w_complete & ~r_wr_sel);
    assign w_full_nxt[1] = (r_full[1] & ~(w_read &  r_rd_sel)) | (w_complete &  r_wr_sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_buf[i] <= '0;
            end
            r_full     <= 2'b00;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.RXFlush) begin
                r_bit_cnt       <= '0;
                r_buf[r_wr_sel] <= '0;
            end else if (w_accept) begin
                r_buf[r_wr_sel] <= w_shifted;
                if (w_complete) begin
                    r_bit_cnt <= '0;
                    r_wr_sel  <= ~r_wr_sel;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end

            r_full <= w_full_nxt;

            if (w_read) begin
                r_rd_sel <= ~r_rd_sel;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.ClearOvf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.RXOut       = r_buf[r_rd_sel];
    assign bus.RXValid     = r_full[r_rd_sel];
    assign bus.RXBuff0Full = r_full[0];
    assign bus.RXBuff1Full = r_full[1];
    assign bus.wrSel       = r_wr_sel;
    assign bus.rdSel       = r_rd_sel;
    assign bus.bitCount    = r_bit_cnt;
    assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rx_data_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_data_path
// Brief    : Directed self-checking bench; an MSB-first and an LSB-first
//            instance share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_data_path;
    logic clk;
    logic reset;
    logic r_start, r_shift, r_din, r_flush, r_rd, r_clrovf;

    int total = 0;
    int bad   = 0;

    rx_data_path_if #(.WIDTH(32)) bus_m ();
    rx_data_path_if #(.WIDTH(32)) bus_l ();

    assign bus_m.StartRX  = r_start;
    assign bus_m.ShiftRX  = r_shift;
    assign bus_m.RXIn     = r_din;
    assign bus_m.RXFlush  = r_flush;
    assign bus_m.RXRead   = r_rd;
    assign bus_m.ClearOvf = r_clrovf;
    assign bus_l.StartRX  = r_start;
    assign bus_l.ShiftRX  = r_shift;
    assign bus_l.RXIn     = r_din;
    assign bus_l.RXFlush  = r_flush;
    assign bus_l.RXRead   = r_rd;
    assign bus_l.ClearOvf = r_clrovf;

    rx_data_path #(.WIDTH(32), .MSB_FIRST(1)) u_dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    rx_data_path #(.WIDTH(32), .MSB_FIRST(0)) u_dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        r_shift = 1'b1;
        r_din   = b;
        tick();
        r_shift = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_msb(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic send_lsb(input logic [31:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(w[i]);
    endtask

    initial begin
        reset = 1'b1; r_start = 1'b0; r_shift = 1'b0; r_din = 1'b0;
        r_flush = 1'b0; r_rd = 1'b0; r_clrovf = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_out",   bus_m.RXOut, 32'h0);
        chk("rst_valid", 32'(bus_m.RXValid), 32'd0);
        chk("rst_full",  32'({bus_m.RXBuff1Full, bus_m.RXBuff0Full}), 32'd0);
        chk("rst_sel",   32'({bus_m.wrSel, bus_m.rdSel}), 32'd0);
        chk("rst_cnt",   32'(bus_m.bitCount), 32'd0);
        chk("rst_ovf",   32'(bus_m.overflow), 32'd0);

        // Single word, MSB first
        r_start = 1'b1;
        send_msb(32'hA5A50F0F, 31, 1);
        chk("w1_cnt31",   32'(bus_m.bitCount), 32'd31);
        chk("w1_novalid", 32'(bus_m.RXValid), 32'd0);
        send_msb(32'hA5A50F0F, 0, 0);
        chk("w1_valid", 32'(bus_m.RXValid), 32'd1);
        chk("w1_out",   bus_m.RXOut, 32'hA5A50F0F);
        chk("w1_full0", 32'(bus_m.RXBuff0Full), 32'd1);
        chk("w1_wrsel", 32'(bus_m.wrSel), 32'd1);
        chk("w1_cnt0",  32'(bus_m.bitCount), 32'd0);
        r_rd = 1'b1; tick(); r_rd = 1'b0;
        chk("w1_rd_valid", 32'(bus_m.RXValid), 32'd0);
        chk("w1_rd_rdsel", 32'(bus_m.rdSel), 32'd1);
        r_rd = 1'b1; tick(); r_rd = 1'b0;
        chk("w1_rd_ignored", 32'(bus_m.rdSel), 32'd1);

        // Ping-pong, then overflow
        do_reset();
        r_start = 1'b1;
        send_msb(32'h12345678, 31, 0);
        send_msb(32'hDEADBEEF, 31, 0);
        chk("pp_full", 32'({bus_m.RXBuff1Full, bus_m.RXBuff0Full}), 32'd3);
        chk("pp_out",  bus_m.RXOut, 32'h12345678);
        chk("pp_wrsel", 32'(bus_m.wrSel), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        chk("ov_flag", 32'(bus_m.overflow), 32'd1);
        chk("ov_cnt",  32'(bus_m.bitCount), 32'd0);
        chk("ov_out",  bus_m.RXOut, 32'h12345678);
        r_clrovf = 1'b1;
        send_bit(1'b1);
        chk("ov_clr_and_drop", 32'(bus_m.overflow), 32'd1);
        tick();
        r_clrovf = 1'b0;
        chk("ov_clr", 32'(bus_m.overflow), 32'd0);
        r_rd = 1'b1; tick(); r_rd = 1'b0;
        chk("pp_rd_out",   bus_m.RXOut, 32'hDEADBEEF);
        chk("pp_rd_valid", 32'(bus_m.RXValid), 32'd1);
        chk("pp_rd_full0", 32'(bus_m.RXBuff0Full), 32'd0);

        // Read on the same edge as completion into the other buffer
        do_reset();
        r_start = 1'b1;
        send_msb(32'hCAFEF00D, 31, 0);
        send_msb(32'h0F1E2D3C, 31, 1);
        chk("col_pre_valid", 32'(bus_m.RXValid), 32'd1);
        r_rd = 1'b1;
        send_msb(32'h0F1E2D3C, 0, 0);
        r_rd = 1'b0;
        chk("col_full",  32'({bus_m.RXBuff1Full, bus_m.RXBuff0Full}), 32'd2);
        chk("col_rdsel", 32'(bus_m.rdSel), 32'd1);
        chk("col_valid", 32'(bus_m.RXValid), 32'd1);
        chk("col_out",   bus_m.RXOut, 32'h0F1E2D3C);

        // StartRX pause mid-word on the LSB-first instance
        do_reset();
        r_start = 1'b1;
        send_lsb(32'h0000FFFF, 0, 9);
        chk("pause_cnt_a", 32'(bus_l.bitCount), 32'd10);
        r_start = 1'b0;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("pause_cnt_b", 32'(bus_l.bitCount), 32'd10);
        r_start = 1'b1;
        send_lsb(32'h0000FFFF, 10, 31);
        chk("pause_out",   bus_l.RXOut, 32'h0000FFFF);
        chk("pause_valid", 32'(bus_l.RXValid), 32'd1);

        // Flush, coinciding with a strobe
        send_lsb(32'h000003FF, 0, 9);
        chk("fl_cnt_pre", 32'(bus_l.bitCount), 32'd10);
        r_flush = 1'b1;
        send_bit(1'b1);
        r_flush = 1'b0;
        chk("fl_cnt",   32'(bus_l.bitCount), 32'd0);
        chk("fl_full",  32'({bus_l.RXBuff1Full, bus_l.RXBuff0Full}), 32'd1);
        chk("fl_wrsel", 32'(bus_l.wrSel), 32'd1);

        // Reset mid-word
        do_reset();
        r_start = 1'b1;
        send_msb(32'h55AA55AA, 31, 0);
        send_msb(32'h7F000000, 31, 25);
        chk("mr_cnt_pre", 32'(bus_m.bitCount), 32'd7);
        do_reset();
        chk("mr_out",   bus_m.RXOut, 32'h0);
        chk("mr_valid", 32'(bus_m.RXValid), 32'd0);
        chk("mr_full",  32'({bus_m.RXBuff1Full, bus_m.RXBuff0Full}), 32'd0);
        chk("mr_cnt",   32'(bus_m.bitCount), 32'd0);
        chk("mr_sel",   32'({bus_m.wrSel, bus_m.rdSel}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
